// File: rtl/rng_pkg.sv
// Shared types and helpers for the range-limited random requester.
package rng_pkg;

  typedef enum logic [1:0] {StIdle, StFetch, StSample, StDone} state_e;

  // Power-on seed of the paired LFSR generator.
  localparam logic [15:0] RNG_SEED = 16'hA7E2;

  // Widest operand cover_mask handles; callers zero-extend into it.
  localparam int unsigned MAX_W = 16;

  // Smallest 2^k-1 that is >= x: smear the top set bit downward.
  function automatic logic [MAX_W-1:0] cover_mask(input logic [MAX_W-1:0] x);
    logic [MAX_W-1:0] r;
    r = x;
    for (int i = 1; i < MAX_W; i++) begin
      r = r | (r >> i);
    end
    return r;
  endfunction

endpackage

// File: rtl/rng_range_req_if.sv
// Request/result bundle between game logic, this requester and the generator.
interface rng_range_req_if #(
  parameter int unsigned RNG_W = 16,
  parameter int unsigned OUT_W = 8
);
  logic             req;
  logic [OUT_W-1:0] limit;
  logic             busy;
  logic             valid;
  logic [OUT_W-1:0] value;
  logic             rng_get;
  logic [RNG_W-1:0] rng_result;

  // The requester block itself.
  modport slave (
    input  req, limit, rng_result,
    output busy, valid, value, rng_get
  );

  // Whoever drives requests and supplies generator words.
  modport master (
    output req, limit, rng_result,
    input  busy, valid, value, rng_get
  );
endinterface

// File: rtl/rng_range_req.sv
// Uniform integer in [0, limit) by mask-and-reject over fresh generator words,
// with a bounded number of attempts and a subtract-once fallback.
module rng_range_req
  import rng_pkg::*;
#(
  parameter int unsigned RNG_W     = 16,
  parameter int unsigned OUT_W     = 8,
  parameter int unsigned MAX_TRIES = 8
) (
  input  logic           clk,
  input  logic           rst,
  rng_range_req_if.slave bus
);

  localparam int unsigned TW = $clog2(MAX_TRIES + 1);

  state_e           state_q, state_d;
  logic [OUT_W-1:0] lim_q, mask_q, value_q;
  logic [TW-1:0]    tries_q;
  logic [OUT_W-1:0] cand;
  logic [OUT_W-1:0] lim_m1;
  logic [OUT_W-1:0] mask_new;
  logic             accept;
  logic             last_try;

  assign cand     = bus.rng_result[OUT_W-1:0] & mask_q;
  assign lim_m1   = bus.limit - 1'b1;
  // limit of 0 or 1 has nothing to mask; 0 would also wrap lim_m1.
  assign mask_new = (bus.limit <= OUT_W'(1)) ? '0 : OUT_W'(cover_mask(MAX_W'(lim_m1)));
  assign accept   = cand < lim_q;
  assign last_try = tries_q == TW'(MAX_TRIES);

  if (RNG_W > OUT_W) begin : g_unused
    logic unused_hi;
    assign unused_hi = ^bus.rng_result[RNG_W-1:OUT_W];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (bus.req) state_d = (bus.limit == '0) ? StDone : StFetch;
      StFetch:  state_d = StSample;
      StSample: state_d = (accept || last_try) ? StDone : StFetch;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    bus.busy    = state_q != StIdle;
    bus.valid   = state_q == StDone;
    bus.rng_get = state_q == StFetch;
  end

  assign bus.value = value_q;

  // Request latch, attempt counter and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      lim_q   <= '0;
      mask_q  <= '0;
      value_q <= '0;
      tries_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.req) begin
            lim_q   <= bus.limit;
            mask_q  <= mask_new;
            tries_q <= '0;
            if (bus.limit == '0) value_q <= '0;
          end
        end
        StFetch: tries_q <= tries_q + 1'b1;
        StSample: begin
          // cand <= mask < 2*lim, so one subtraction always lands in range.
          if (accept)        value_q <= cand;
          else if (last_try) value_q <= cand - lim_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rng_range_req.sv
// Directed bench: two requesters (MAX_TRIES 8 and 1) fed by a generator model.
module tb_rng_range_req;
  import rng_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic [7:0] limit = '0;

  int vectors     = 0;
  int miscompares = 0;

  int gets_a = 0, gets_b = 0, valids_a = 0;
  int idx_a = 0, idx_b = 0;
  logic prev_a = 1'b0, prev_b = 1'b0, dbl_get = 1'b0;
  int lat, v0;

  always #5 clk = ~clk;

  rng_range_req_if #(.RNG_W(16), .OUT_W(8)) ifa ();
  rng_range_req_if #(.RNG_W(16), .OUT_W(8)) ifb ();

  // Known post-reset output sequence of the paired generator.
  function automatic logic [15:0] gen_word(input int i);
    case (i)
      0:       return RNG_SEED;
      1:       return 16'h4FC5;
      2:       return 16'h9F8B;
      default: return 16'h3F17;
    endcase
  endfunction

  assign ifa.req        = req;
  assign ifa.limit      = limit;
  assign ifa.rng_result = gen_word(idx_a);
  assign ifb.req        = req;
  assign ifb.limit      = limit;
  assign ifb.rng_result = gen_word(idx_b);

  rng_range_req #(.RNG_W(16), .OUT_W(8), .MAX_TRIES(8)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  rng_range_req #(.RNG_W(16), .OUT_W(8), .MAX_TRIES(1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  // Generator model and event counters.
  always @(posedge clk) begin
    if (rst) begin
      idx_a <= 0; idx_b <= 0; gets_a <= 0; gets_b <= 0;
    end else begin
      if (ifa.rng_get) begin idx_a <= idx_a + 1; gets_a <= gets_a + 1; end
      if (ifb.rng_get) begin idx_b <= idx_b + 1; gets_b <= gets_b + 1; end
    end
    if (ifa.valid) valids_a <= valids_a + 1;
    if ((ifa.rng_get && prev_a) || (ifb.rng_get && prev_b)) dbl_get <= 1'b1;
    prev_a <= ifa.rng_get;
    prev_b <= ifb.rng_get;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Pulse req for one cycle, then wait (bounded) for dut_a's valid.
  task automatic run_req(input logic [7:0] lim, output int l);
    req   = 1'b1;
    limit = lim;
    step();
    req = 1'b0;
    l   = 1;
    while (ifa.valid !== 1'b1 && l < 40) begin
      step();
      l++;
    end
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_busy", 32'(ifa.busy), 0);
    check("rst_valid", 32'(ifa.valid), 0);
    check("rst_value", 32'(ifa.value), 0);
    check("rst_get", 32'(ifa.rng_get), 0);
    check("rst_b_busy", 32'(ifb.busy), 0);

    // 1: limit 200, mask 0xFF, first word 0x4FC5 -> 0xC5
    req = 1'b1; limit = 8'd200;
    step();
    req = 1'b0;
    check("t1_fetch_get", 32'(ifa.rng_get), 1);
    check("t1_fetch_busy", 32'(ifa.busy), 1);
    step();
    check("t1_sample_get", 32'(ifa.rng_get), 0);
    step();
    check("t1_valid", 32'(ifa.valid), 1);
    check("t1_value", 32'(ifa.value), 197);
    check("t1_gets", 32'(gets_a), 1);
    step();
    check("t1_busy_clr", 32'(ifa.busy), 0);
    check("t1_valid_clr", 32'(ifa.valid), 0);
    check("t1_value_hold", 32'(ifa.value), 197);

    // 2: limit 5, mask 7: 5 rejected, 0x8B&7=3 accepted
    do_reset();
    run_req(8'd5, lat);
    check("t2_latency", 32'(lat), 5);
    check("t2_value", 32'(ifa.value), 3);
    check("t2_gets", 32'(gets_a), 2);

    // 3: MAX_TRIES=1, limit 5: 5 rejected, fallback 5-5=0
    do_reset();
    req = 1'b1; limit = 8'd5;
    step();
    req = 1'b0;
    check("t3_get", 32'(ifb.rng_get), 1);
    step();
    step();
    check("t3_valid", 32'(ifb.valid), 1);
    check("t3_value", 32'(ifb.value), 0);
    check("t3_gets", 32'(gets_b), 1);

    // 4: limit 0 goes straight to DONE, no fetch
    do_reset();
    run_req(8'd0, lat);
    check("t4_latency", 32'(lat), 1);
    check("t4_value", 32'(ifa.value), 0);
    check("t4_gets", 32'(gets_a), 0);

    // 5: limit 1 -> 0; then req held high with limit 100 -> 0x8B&0x7F=11
    do_reset();
    run_req(8'd1, lat);
    check("t5a_latency", 32'(lat), 3);
    check("t5a_value", 32'(ifa.value), 0);
    check("t5a_gets", 32'(gets_a), 1);
    req = 1'b1; limit = 8'd100;
    step();
    check("t5_gap_busy", 32'(ifa.busy), 0);
    check("t5_gap_get", 32'(ifa.rng_get), 0);
    step();
    check("t5b_get", 32'(ifa.rng_get), 1);
    req = 1'b0;
    step();
    step();
    check("t5b_valid", 32'(ifa.valid), 1);
    check("t5b_value", 32'(ifa.value), 11);
    check("t5b_gets", 32'(gets_a), 2);

    // 6: reset while in SAMPLE aborts; stray req mid-operation ignored
    step();
    req = 1'b1; limit = 8'd200;
    step();
    req = 1'b0;
    step();
    check("t6_in_sample", 32'(ifa.busy), 1);
    v0  = valids_a;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_abort_busy", 32'(ifa.busy), 0);
    check("t6_abort_valid", 32'(ifa.valid), 0);
    check("t6_abort_value", 32'(ifa.value), 0);
    req = 1'b1; limit = 8'd200;
    step();
    req = 1'b0;
    step();
    req = 1'b1; limit = 8'd3;
    step();
    req = 1'b0;
    check("t6_valid", 32'(ifa.valid), 1);
    check("t6_value", 32'(ifa.value), 197);
    step();
    check("t6_idle_busy", 32'(ifa.busy), 0);
    check("t6_value_hold", 32'(ifa.value), 197);
    step();
    check("t6_valid_count", 32'(valids_a - v0), 1);
    check("t6_busy_stays", 32'(ifa.busy), 0);

    check("no_double_get", 32'(dbl_get), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
